beat_phase_sequencer: RTL and testbench



---
 rtl/beat_phase_sequencer.sv | 166 ++++++++++++++++
 tb/tb_beat_phase_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_phase_sequencer.sv
// Beat/phase sequencer feeding a 74LS191 down-counter: presets it, counts, alternates SCAN/ACTION.
// Define BEAT_SEQ_TIMEOUT_EN to add a COUNT-state timeout that latches FAULT until CLR.
module beat_phase_sequencer #(
  parameter logic [3:0]  SCAN_PRESET    = 4'd9,
  parameter logic [3:0]  ACTION_PRESET  = 4'd4,
  parameter int unsigned LOAD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 20
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       RUN,
  input  logic       STEP,
  input  logic       RCO_n,
  output logic [3:0] D,
  output logic       LOAD_n,
  output logic       CTEN_n,
  output logic       DOWN_UP_n,
  output logic       SCAN,
  output logic       ACTION,
  output logic       PHASE_END,
  output logic       FAULT
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCount,
    StEnd
`ifdef BEAT_SEQ_TIMEOUT_EN
    , StFault
`endif
  } state_e;

  localparam logic [2:0] LoadLast = 3'(LOAD_CYCLES - 1);

`ifdef BEAT_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0] tmo_cnt_q;
`else
  // The timeout length is meaningless without the timeout logic.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  state_e     state_q;
  logic       next_scan_q;
  logic       step_q;
  logic [2:0] load_cnt_q;
  logic [3:0] d_q;
  logic       load_n_q;
  logic       cten_n_q;
  logic       down_up_n_q;
  logic       scan_q;
  logic       action_q;
  logic       phase_end_q;
  logic       fault_q;

  logic       step_rise;
  logic       start_req;
  logic [3:0] next_preset;

  assign step_rise   = STEP & ~step_q;
  assign start_req   = RUN | step_rise;
  assign next_preset = next_scan_q ? SCAN_PRESET : ACTION_PRESET;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= StIdle;
      next_scan_q <= 1'b1;
      step_q      <= 1'b0;
      load_cnt_q  <= 3'd0;
      d_q         <= 4'd0;
      load_n_q    <= 1'b1;
      cten_n_q    <= 1'b1;
      down_up_n_q <= 1'b1;
      scan_q      <= 1'b0;
      action_q    <= 1'b0;
      phase_end_q <= 1'b0;
      fault_q     <= 1'b0;
`ifdef BEAT_SEQ_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      step_q <= STEP;
      unique case (state_q)
        StIdle: begin
          if (start_req) begin
            state_q    <= StLoad;
            load_cnt_q <= 3'd0;
            d_q        <= next_preset;
            load_n_q   <= 1'b0;
            scan_q     <= next_scan_q;
            action_q   <= ~next_scan_q;
          end
        end
        StLoad: begin
          if (load_cnt_q == LoadLast) begin
            state_q  <= StCount;
            load_n_q <= 1'b1;
            cten_n_q <= 1'b0;
`ifdef BEAT_SEQ_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
          end else begin
            load_cnt_q <= load_cnt_q + 3'd1;
          end
        end
        StCount: begin
          // The counter also steps on this edge and wraps; the next LOAD fixes that.
          if (!RCO_n) begin
            state_q     <= StEnd;
            cten_n_q    <= 1'b1;
            phase_end_q <= 1'b1;
            next_scan_q <= ~next_scan_q;
          end
`ifdef BEAT_SEQ_TIMEOUT_EN
          else if (tmo_cnt_q == TmoLast) begin
            state_q  <= StFault;
            cten_n_q <= 1'b1;
            load_n_q <= 1'b1;
            scan_q   <= 1'b0;
            action_q <= 1'b0;
            fault_q  <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
`endif
        end
        StEnd: begin
          phase_end_q <= 1'b0;
          if (RUN) begin
            state_q    <= StLoad;
            load_cnt_q <= 3'd0;
            d_q        <= next_preset;
            load_n_q   <= 1'b0;
            scan_q     <= next_scan_q;
            action_q   <= ~next_scan_q;
          end else begin
            state_q  <= StIdle;
            scan_q   <= 1'b0;
            action_q <= 1'b0;
          end
        end
`ifdef BEAT_SEQ_TIMEOUT_EN
        StFault: begin
          fault_q <= 1'b1;
        end
`endif
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign D         = d_q;
  assign LOAD_n    = load_n_q;
  assign CTEN_n    = cten_n_q;
  assign DOWN_UP_n = down_up_n_q;
  assign SCAN      = scan_q;
  assign ACTION    = action_q;
  assign PHASE_END = phase_end_q;
  assign FAULT     = fault_q;

endmodule

// File: tb/tb_beat_phase_sequencer.sv
// Bench for beat_phase_sequencer: two instances (default presets, ACTION_PRESET=0) each driving
// a 74LS191 model, checked cycle by cycle against a phase-position reference model.
module tb_beat_phase_sequencer;

  localparam int LC = 2;

  logic clk       = 1'b0;
  logic clr       = 1'b0;
  logic run       = 1'b0;
  logic step      = 1'b0;
  logic force_rco = 1'b0;

  logic [3:0] d         [2];
  logic       load_n    [2];
  logic       cten_n    [2];
  logic       down_up_n [2];
  logic       scan      [2];
  logic       action    [2];
  logic       pe        [2];
  logic       fault     [2];
  logic       rco_n     [2];
  logic [3:0] cq        [2] = '{4'd0, 4'd0};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit checking_en = 1'b1;

  // Reference model: per instance, idle flag or position within the current phase.
  bit m_idle      [2];
  bit m_scan      [2];
  bit m_next_scan [2];
  int m_t         [2];
  int m_d         [2];
  bit m_step_prev;

  int pe1 [2];
  int pe2 [2];
  int pe_cnt;

  always #5 clk = ~clk;

  beat_phase_sequencer u_dut_dflt (
    .CLK       (clk),
    .CLR       (clr),
    .RUN       (run),
    .STEP      (step),
    .RCO_n     (rco_n[0]),
    .D         (d[0]),
    .LOAD_n    (load_n[0]),
    .CTEN_n    (cten_n[0]),
    .DOWN_UP_n (down_up_n[0]),
    .SCAN      (scan[0]),
    .ACTION    (action[0]),
    .PHASE_END (pe[0]),
    .FAULT     (fault[0])
  );

  beat_phase_sequencer #(
    .ACTION_PRESET (4'd0)
  ) u_dut_act0 (
    .CLK       (clk),
    .CLR       (clr),
    .RUN       (run),
    .STEP      (step),
    .RCO_n     (rco_n[1]),
    .D         (d[1]),
    .LOAD_n    (load_n[1]),
    .CTEN_n    (cten_n[1]),
    .DOWN_UP_n (down_up_n[1]),
    .SCAN      (scan[1]),
    .ACTION    (action[1]),
    .PHASE_END (pe[1]),
    .FAULT     (fault[1])
  );

  // 74LS191 behaviour in down-count mode.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!load_n[k]) cq[k] <= d[k];
      else if (!cten_n[k]) cq[k] <= cq[k] - 4'd1;
    end
  end

  assign rco_n[0] = force_rco | ~((cq[0] == 4'd0) & ~cten_n[0]);
  assign rco_n[1] = force_rco | ~((cq[1] == 4'd0) & ~cten_n[1]);

  function automatic int preset(input int k, input bit s);
    if (s) return 9;
    return (k == 0) ? 4 : 0;
  endfunction

  function automatic int phase_len(input int k, input bit s);
    return LC + preset(k, s) + 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idle[k]      = 1'b1;
      m_scan[k]      = 1'b0;
      m_next_scan[k] = 1'b1;
      m_t[k]         = 0;
      m_d[k]         = 0;
    end
    m_step_prev = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    rise = step && !m_step_prev;
    m_step_prev = step;
    for (int k = 0; k < 2; k++) begin
      if (m_idle[k]) begin
        if (run || rise) begin
          m_idle[k] = 1'b0;
          m_scan[k] = m_next_scan[k];
          m_t[k]    = 0;
          m_d[k]    = preset(k, m_scan[k]);
        end
      end else if (m_t[k] == phase_len(k, m_scan[k]) - 1) begin
        m_next_scan[k] = !m_scan[k];
        if (run) begin
          m_scan[k] = m_next_scan[k];
          m_t[k]    = 0;
          m_d[k]    = preset(k, m_scan[k]);
        end else begin
          m_idle[k] = 1'b1;
        end
      end else begin
        m_t[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int pre;
      bit busy, in_load, in_count, in_end;
      pre      = preset(k, m_scan[k]);
      busy     = !m_idle[k];
      in_load  = busy && (m_t[k] < LC);
      in_count = busy && (m_t[k] >= LC) && (m_t[k] < LC + pre + 1);
      in_end   = busy && (m_t[k] == LC + pre + 1);
      check($sformatf("u%0d.D@%0d", k, cyc), 32'(d[k]), 32'(m_d[k]));
      check($sformatf("u%0d.LOAD_n@%0d", k, cyc), 32'(load_n[k]), 32'(!in_load));
      check($sformatf("u%0d.CTEN_n@%0d", k, cyc), 32'(cten_n[k]), 32'(!in_count));
      check($sformatf("u%0d.DOWN_UP_n@%0d", k, cyc), 32'(down_up_n[k]), 32'd1);
      check($sformatf("u%0d.SCAN@%0d", k, cyc), 32'(scan[k]), 32'(busy && m_scan[k]));
      check($sformatf("u%0d.ACTION@%0d", k, cyc), 32'(action[k]), 32'(busy && !m_scan[k]));
      check($sformatf("u%0d.PHASE_END@%0d", k, cyc), 32'(pe[k]), 32'(in_end));
      check($sformatf("u%0d.FAULT@%0d", k, cyc), 32'(fault[k]), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (clr) model_reset();
    else model_step();
    #1;
    if (checking_en) check_all();
  endtask

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #2 clr = 1'b1;
    #1 model_reset();
    check_all();
    tick();
    tick();
    clr = 1'b0;
    run = 1'b1;

    // Free run: SCAN ends at clock 13, ACTION 8 (or 4 with preset 0) clocks later.
    pe1 = '{-1, -1};
    pe2 = '{-1, -1};
    for (int i = 1; i <= 42; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (pe[k]) begin
          if (pe1[k] < 0) pe1[k] = i;
          else if (pe2[k] < 0) pe2[k] = i;
        end
      end
    end
    check("u0.scan_end_clk", 32'(pe1[0]), 32'd13);
    check("u0.action_end_clk", 32'(pe2[0]), 32'd21);
    check("u1.scan_end_clk", 32'(pe1[1]), 32'd13);
    check("u1.action_end_clk", 32'(pe2[1]), 32'd17);
    run = 1'b0;
    repeat (20) tick();

    // Single steps, then STEP held high.
    repeat (3) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (20) tick();
    end
    step   = 1'b1;
    pe_cnt = 0;
    repeat (30) begin
      tick();
      if (pe[0]) pe_cnt++;
    end
    step = 1'b0;
    repeat (5) tick();
    check("u0.held_step_phases", 32'(pe_cnt), 32'd1);

    // RUN dropped in the fifth COUNT clock of a SCAN phase, then reasserted.
    run = 1'b1;
    repeat (7) tick();
    run = 1'b0;
    repeat (20) tick();
    run = 1'b1;
    tick();
    check("u0.resume_D", 32'(d[0]), 32'd4);
    check("u0.resume_action", 32'(action[0]), 32'd1);
    repeat (5) tick();

    // CLR mid-cycle during COUNT.
    #3 clr = 1'b1;
    #1 model_reset();
    check_all();
    tick();
    tick();
    clr = 1'b0;
    tick();
    check("u0.restart_scan", 32'(scan[0]), 32'd1);
    check("u0.restart_D", 32'(d[0]), 32'd9);
    repeat (20) tick();

    // Randomised RUN/STEP.
    repeat (800) begin
      if ($urandom_range(15) == 0) run = ~run;
      step = ($urandom_range(3) == 0);
      tick();
    end
    step = 1'b0;

    // Counter never reaches zero.
    run = 1'b0;
    clr = 1'b1;
    tick();
    checking_en = 1'b0;
    force_rco   = 1'b1;
    clr         = 1'b0;
    run         = 1'b1;
    repeat (22) tick();
`ifdef BEAT_SEQ_TIMEOUT_EN
    for (int k = 0; k < 2; k++) check($sformatf("u%0d.fault_early", k), 32'(fault[k]), 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.fault_set", k), 32'(fault[k]), 32'd1);
      check($sformatf("u%0d.fault_cten_n", k), 32'(cten_n[k]), 32'd1);
      check($sformatf("u%0d.fault_load_n", k), 32'(load_n[k]), 32'd1);
      check($sformatf("u%0d.fault_scan", k), 32'(scan[k]), 32'd0);
    end
    force_rco = 1'b0;
    repeat (10) tick();
    for (int k = 0; k < 2; k++) check($sformatf("u%0d.fault_stuck", k), 32'(fault[k]), 32'd1);
`else
    repeat (18) tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d.hang_fault", k), 32'(fault[k]), 32'd0);
      check($sformatf("u%0d.hang_cten_n", k), 32'(cten_n[k]), 32'd0);
      check($sformatf("u%0d.hang_scan", k), 32'(scan[k]), 32'd1);
    end
`endif
    clr = 1'b1;
    tick();
    clr         = 1'b0;
    force_rco   = 1'b0;
    checking_en = 1'b1;
    repeat (30) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
